seq_det_sched: RTL and testbench
================================

Name: seq_det_sched

Overview:
Shared-resource scheduler for a bit-serial pattern detector.
- Accepts parallel words from NREQ requesters and arbitrates round-robin.
- Serializes the granted word MSB-first into one programmable detector core.
- Counts detected patterns and returns the count with the requester ID over a valid/ready response port.
- Lets several producers share one detector instead of instantiating one detector per bit stream.

Parameters:
NREQ, 4, number of requesters (2..8)
WORD_W, 16, bits per request word
PAT_W, 4, pattern length in bits (2..WORD_W)
CNT_W, 5, match-count width; count saturates at 2^CNT_W-1

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
req_valid  in  NREQ  per-requester word valid
req_data  in  NREQ*WORD_W  request words; requester i at bits [i*WORD_W +: WORD_W]
req_ready  out  NREQ  one-hot grant/accept; transfer when valid&ready
pattern  in  PAT_W  target pattern, MSB is first bit expected
rsp_valid  out  1  response available
rsp_ready  in  1  response accepted when valid&ready
rsp_id  out  $clog2(NREQ)  requester index of the response
rsp_count  out  CNT_W  matches found in the word
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset, asynchronous: state=IDLE, rr pointer=0, req_ready=0, rsp_valid=0, rsp_id=0, rsp_count=0, busy=0, detector history/fill cleared.
- FSM states: IDLE, SHIFT, DRAIN, RESP.
- IDLE
  - req_ready is a combinational one-hot grant of the first valid requester at or after the rr pointer; it is 0 if no requester is valid.
  - On transfer: capture the word, the ID and the pattern; clear the count; clear the detector; set rr pointer = grant+1 mod NREQ; go to SHIFT.
- SHIFT
  - Runs for exactly WORD_W cycles with a bit counter.
  - Each cycle feeds the next bit, MSB first, to the detector.
  - Moves to DRAIN after the last bit.
- DRAIN
  - One cycle that absorbs the registered detector output for the last bit.
  - Goes to RESP.
- Count rule: the count increments on every cycle the detector match output is 1, in SHIFT or DRAIN. It saturates at all-ones and never wraps.
- RESP
  - rsp_valid=1, with rsp_id and rsp_count held stable.
  - On rsp_ready, goes to IDLE the next cycle.
  - No grant is issued while in RESP (back-pressure).
- Latency: transfer in cycle T, bits in T+1..T+WORD_W, DRAIN at T+WORD_W+1, rsp_valid first high at T+WORD_W+2.
- Throughput: at most one word per WORD_W+3 cycles.
- Detector (Moore, registered output)
  - Holds a PAT_W-bit history register and a fill counter.
  - match=1 in the cycle after the bit that makes history==pattern with fill>=PAT_W.
  - Non-overlapping: a match clears the fill counter, so the next match needs PAT_W fresh bits.
  - The detector is cleared at every grant; matches never span two words.
- Boundary conditions:
  - A change on the pattern input during SHIFT has no effect; only the captured copy is used.
  - A requester dropping req_valid while not granted is legal.
  - When all requesters are valid, grants rotate 0,1,2,3,0...
  - Reset mid-word aborts the operation and emits no response.

Optional Feature:
SEQ_DET_OVERLAP_EN
- Defined: the detector does not clear the fill counter on a match, so overlapping occurrences are each counted.
- Undefined: non-overlapping behaviour as above.
- Ports are identical in both builds.

Decomposition:
- Shared package seq_det_pkg holds:
  - the FSM state typedef (IDLE, SHIFT, DRAIN, RESP);
  - the localparam helper for ID width.
- One sub-module, seq_det_core: the programmable history/fill detector with inputs clk, rst_n, clr, bit_vld, bit_in, pattern and output match.
- seq_det_sched contains the arbiter, serializer, counter and FSM.

Test Plan:
- Pattern 4'b1011; requester 0 sends 16'hB0B0 -> rsp_id=0, rsp_count=2; rsp_valid at T+18.
- Pattern 4'b1011; word 16'b1011_0110_1100_0000 -> count=2 without the macro, count=3 with SEQ_DET_OVERLAP_EN.
- All 4 requesters valid continuously, distinct words -> grants in order 0,1,2,3,0; each response ID matches.
- Hold rsp_ready=0 for 10 cycles in RESP -> rsp fields stable, all req_ready=0; accept, then the next grant occurs the cycle after returning to IDLE.
- Pattern 4'b0000, word 16'h0000 -> count=4 (non-overlap) or 13 (overlap); with CNT_W=3 the overlap build saturates at 7.
- Assert rst_n low during SHIFT cycle 5 -> all outputs return to reset values, no response; next request completes normally.

Source files
------------

// File: rtl/seq_det_pkg.sv
// -----------------------------------------------------------------------------
// seq_det_pkg
// Shared declarations for the bit-serial pattern-detector scheduler.
//   state_t  : scheduler FSM states (IDLE, SHIFT, DRAIN, RESP)
//   id_width : width of a requester index for a given requester count
// Optional build macro used elsewhere in this slice: SEQ_DET_OVERLAP_EN
// -----------------------------------------------------------------------------
package seq_det_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DRAIN = 2'd2,
      RESP  = 2'd3
   } state_t;

   // Width of a requester index; never less than one bit.
   function automatic int id_width(input int nreq);
      return (nreq > 1) ? $clog2(nreq) : 1;
   endfunction

endpackage

// File: rtl/seq_det_core.sv
// -----------------------------------------------------------------------------
// seq_det_core
// Programmable bit-serial pattern detector with a registered (Moore) output.
// Keeps a PAT_W-bit history of the incoming bits and a fill counter telling
// how many of those history bits are valid since the last clear / match.
//
// Ports:
//   clk      in   clock
//   rst_n    in   asynchronous active-low reset
//   clr      in   synchronous clear of history, fill and match
//   bit_vld  in   bit_in is a new serial bit this cycle
//   bit_in   in   serial data bit
//   pattern  in   target pattern, MSB is the first bit expected
//   match    out  high the cycle after the bit that completes the pattern
//
// Build option SEQ_DET_OVERLAP_EN:
//   defined   -> fill is kept on a match, overlapping occurrences all count
//   undefined -> fill restarts on a match, the next hit needs PAT_W new bits
// -----------------------------------------------------------------------------
module seq_det_core #(
   parameter int PAT_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             bit_vld,
   input  logic             bit_in,
   input  logic [PAT_W-1:0] pattern,
   output logic             match
);

`ifdef SEQ_DET_OVERLAP_EN
   localparam bit OVERLAP = 1'b1;
`else
   localparam bit OVERLAP = 1'b0;
`endif

   localparam int               FILL_W    = $clog2(PAT_W + 1);
   localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

   logic [PAT_W-1:0]  hist_q, hist_d, hist_shift;
   logic [FILL_W-1:0] fill_q, fill_d, fill_inc;
   logic              match_q, match_d;
   logic              hit;

   always_comb begin
      // NOTE: every variable gets a default before any branch, so no path
      // through this block leaves one unassigned and no latch is inferred.
      hist_d     = hist_q;
      fill_d     = fill_q;
      match_d    = 1'b0;
      hit        = 1'b0;
      hist_shift = {hist_q[PAT_W-2:0], bit_in};
      // Fill saturates at PAT_W: "history is full" is all we need to know.
      fill_inc   = (fill_q == FILL_FULL) ? fill_q : fill_q + FILL_W'(1);

      if (clr) begin
         hist_d = '0;
         fill_d = '0;
      end else if (bit_vld) begin
         hist_d  = hist_shift;
         fill_d  = fill_inc;
         hit     = (hist_shift == pattern) && (fill_inc == FILL_FULL);
         match_d = hit;
         if (hit && !OVERLAP) begin
            fill_d = '0;
         end
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // its _d value from before the edge, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hist_q  <= '0;
         fill_q  <= '0;
         match_q <= 1'b0;
      end else begin
         hist_q  <= hist_d;
         fill_q  <= fill_d;
         match_q <= match_d;
      end
   end

   assign match = match_q;

endmodule

// File: rtl/seq_det_sched.sv
// -----------------------------------------------------------------------------
// seq_det_sched
// Lets NREQ producers share one bit-serial pattern detector. A round-robin
// arbiter accepts one parallel word, the word is shifted MSB-first into
// seq_det_core, matches are counted (saturating), and the count is returned
// with the requester index over a valid/ready response port.
//
// Ports:
//   clk        in   clock
//   rst_n      in   asynchronous active-low reset
//   req_valid  in   [NREQ]          per-requester word valid
//   req_data   in   [NREQ*WORD_W]   requester i at [i*WORD_W +: WORD_W]
//   req_ready  out  [NREQ]          one-hot grant, only while IDLE
//   pattern    in   [PAT_W]         target pattern, sampled at the grant
//   rsp_valid  out                  response available (RESP state)
//   rsp_ready  in                   response accepted when valid & ready
//   rsp_id     out  [clog2(NREQ)]   requester index of the response
//   rsp_count  out  [CNT_W]         matches found, saturating at all-ones
//   busy       out                  high in every state except IDLE
//
// Timing: transfer in cycle T, bits in T+1..T+WORD_W, DRAIN at T+WORD_W+1,
// rsp_valid from T+WORD_W+2. One word per WORD_W+3 cycles at best.
//
// Build option SEQ_DET_OVERLAP_EN (see seq_det_core): overlapping matches.
// -----------------------------------------------------------------------------
module seq_det_sched
   import seq_det_pkg::*;
#(
   parameter int NREQ   = 4,
   parameter int WORD_W = 16,
   parameter int PAT_W  = 4,
   parameter int CNT_W  = 5
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NREQ-1:0]           req_valid,
   input  logic [NREQ*WORD_W-1:0]    req_data,
   output logic [NREQ-1:0]           req_ready,
   input  logic [PAT_W-1:0]          pattern,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [id_width(NREQ)-1:0] rsp_id,
   output logic [CNT_W-1:0]          rsp_count,
   output logic                      busy
);

   localparam int                ID_W     = id_width(NREQ);
   localparam int                BCNT_W   = $clog2(WORD_W + 1);
   localparam logic [BCNT_W-1:0] LAST_BIT = BCNT_W'(WORD_W - 1);
   localparam logic [ID_W-1:0]   LAST_ID  = ID_W'(NREQ - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

   state_t              state_q, state_d;
   logic [ID_W-1:0]     rr_q, rr_d;
   logic [ID_W-1:0]     id_q, id_d;
   logic [WORD_W-1:0]   word_q, word_d;
   logic [BCNT_W-1:0]   bit_cnt_q, bit_cnt_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [PAT_W-1:0]    pat_q, pat_d;

   logic [ID_W-1:0]     cand;
   logic [ID_W-1:0]     gnt_idx;
   logic                gnt_any;
   logic [NREQ-1:0]     gnt_oh;
   logic                core_clr;
   logic                core_vld;
   logic                core_match;

   // ---------------------------------------------------------------------------
   // Round-robin arbiter: first valid requester at or after rr_q, walking the
   // candidate index with an explicit wrap so NREQ need not be a power of two.
   // ---------------------------------------------------------------------------
   always_comb begin
      gnt_any = 1'b0;
      gnt_idx = '0;
      gnt_oh  = '0;
      cand    = rr_q;
      for (int i = 0; i < NREQ; i++) begin
         if (!gnt_any && req_valid[cand]) begin
            gnt_any = 1'b1;
            gnt_idx = cand;
         end
         cand = (cand == LAST_ID) ? '0 : cand + ID_W'(1);
      end
      if (gnt_any) begin
         gnt_oh[gnt_idx] = 1'b1;
      end
   end

   // ---------------------------------------------------------------------------
   // FSM next-state, serializer and match counter.
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d   = state_q;
      rr_d      = rr_q;
      id_d      = id_q;
      word_d    = word_q;
      bit_cnt_d = bit_cnt_q;
      cnt_d     = cnt_q;
      pat_d     = pat_q;
      req_ready = '0;
      core_clr  = 1'b0;
      core_vld  = 1'b0;

      unique case (state_q)
         IDLE: begin
            // The grant is offered only here, so RESP back-pressures requesters.
            req_ready = gnt_oh;
            // A grant always implies a transfer: gnt_oh selects a valid input.
            if (gnt_any) begin
               word_d    = req_data[int'(gnt_idx)*WORD_W +: WORD_W];
               id_d      = gnt_idx;
               pat_d     = pattern;
               cnt_d     = '0;
               bit_cnt_d = '0;
               core_clr  = 1'b1;
               rr_d      = (gnt_idx == LAST_ID) ? '0 : gnt_idx + ID_W'(1);
               state_d   = SHIFT;
            end
         end
         SHIFT: begin
            core_vld  = 1'b1;
            word_d    = {word_q[WORD_W-2:0], 1'b0};
            bit_cnt_d = bit_cnt_q + BCNT_W'(1);
            if (bit_cnt_q == LAST_BIT) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            // Detector output is registered: the last bit's match shows up here.
            state_d = RESP;
         end
         RESP: begin
            if (rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if ((state_q == SHIFT || state_q == DRAIN) && core_match && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         rr_q      <= '0;
         id_q      <= '0;
         word_q    <= '0;
         bit_cnt_q <= '0;
         cnt_q     <= '0;
         pat_q     <= '0;
      end else begin
         state_q   <= state_d;
         rr_q      <= rr_d;
         id_q      <= id_d;
         word_q    <= word_d;
         bit_cnt_q <= bit_cnt_d;
         cnt_q     <= cnt_d;
         pat_q     <= pat_d;
      end
   end

   // The detector only ever sees the pattern captured at the grant.
   seq_det_core #(
      .PAT_W (PAT_W)
   ) u_core (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (core_clr),
      .bit_vld (core_vld),
      .bit_in  (word_q[WORD_W-1]),
      .pattern (pat_q),
      .match   (core_match)
   );

   assign rsp_valid = (state_q == RESP);
   assign rsp_id    = id_q;
   assign rsp_count = cnt_q;
   assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_seq_det_sched.sv
// -----------------------------------------------------------------------------
// tb_seq_det_sched
// Self-checking bench for seq_det_sched. Main instance uses the default
// parameters; a second instance (NREQ=2, PAT_W=2, CNT_W=3) exercises count
// saturation. Expected responses go into a queue when a word is offered and
// are popped when the response appears. Build with +define+SEQ_DET_OVERLAP_EN
// to check the overlapping-match variant.
// -----------------------------------------------------------------------------
module tb_seq_det_sched;

   localparam int NREQ   = 4;
   localparam int WORD_W = 16;
   localparam int PAT_W  = 4;
   localparam int CNT_W  = 5;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [NREQ-1:0]        req_valid = '0;
   logic [NREQ*WORD_W-1:0] req_data  = '0;
   logic [NREQ-1:0]        req_ready;
   logic [PAT_W-1:0]       pattern   = '0;
   logic                   rsp_valid;
   logic                   rsp_ready = 1'b0;
   logic [1:0]             rsp_id;
   logic [CNT_W-1:0]       rsp_count;
   logic                   busy;

   logic [1:0]  req_valid_s = '0;
   logic [31:0] req_data_s  = '0;
   logic [1:0]  req_ready_s;
   logic [1:0]  pattern_s   = '0;
   logic        rsp_valid_s;
   logic        rsp_ready_s = 1'b1;
   logic [0:0]  rsp_id_s;
   logic [2:0]  rsp_count_s;
   logic        busy_s;

   seq_det_sched #(
      .NREQ(NREQ), .WORD_W(WORD_W), .PAT_W(PAT_W), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
      .pattern(pattern),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_id(rsp_id), .rsp_count(rsp_count), .busy(busy)
   );

   seq_det_sched #(
      .NREQ(2), .WORD_W(16), .PAT_W(2), .CNT_W(3)
   ) dut_sat (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid_s), .req_data(req_data_s), .req_ready(req_ready_s),
      .pattern(pattern_s),
      .rsp_valid(rsp_valid_s), .rsp_ready(rsp_ready_s),
      .rsp_id(rsp_id_s), .rsp_count(rsp_count_s), .busy(busy_s)
   );

   typedef struct packed {
      logic [1:0]       id;
      logic [CNT_W-1:0] cnt;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   // Reference count: scan every window ending at bit k (MSB first). The
   // non-overlapping variant greedily accepts a hit only if it starts after
   // the previous accepted hit ended.
   function automatic int ref_count(input logic [WORD_W-1:0] word,
                                    input logic [PAT_W-1:0] pat);
      int n        = 0;
      int last_end = -100;
      bit hit;
      for (int k = PAT_W - 1; k < WORD_W; k++) begin
         hit = 1'b1;
         for (int m = 0; m < PAT_W; m++) begin
            if (word[WORD_W-1-(k-PAT_W+1+m)] != pat[PAT_W-1-m]) hit = 1'b0;
         end
`ifdef SEQ_DET_OVERLAP_EN
         if (hit) n++;
`else
         if (hit && (k - last_end >= PAT_W)) begin
            n++;
            last_end = k;
         end
`endif
      end
      if (n > (1 << CNT_W) - 1) n = (1 << CNT_W) - 1;
      return n;
   endfunction

   task automatic push_exp(input int id, input int cnt);
      exp_t e;
      e.id  = 2'(id);
      e.cnt = CNT_W'(cnt);
      sb_q.push_back(e);
   endtask

   task automatic pop_exp(output exp_t e);
      e = '0;
      if (sb_q.size() > 0) e = sb_q.pop_front();
   endtask

   // Sample at negedge+1; returns with the cycle of the transfer current.
   task automatic wait_grant(output logic [NREQ-1:0] gnt, output int waited, output bit ok);
      ok = 1'b0;
      gnt = '0;
      waited = 0;
      #1;
      while (!ok && waited < 200) begin
         if ((req_valid & req_ready) != '0) begin
            ok  = 1'b1;
            gnt = req_ready;
         end else begin
            @(negedge clk);
            waited++;
            #1;
         end
      end
   endtask

   // Counts cycles from the current one until rsp_valid is seen at a negedge.
   task automatic wait_rsp(output int lat, output bit ok);
      ok = 1'b0;
      lat = 0;
      while (!ok && lat < 200) begin
         @(negedge clk);
         lat++;
         if (rsp_valid) ok = 1'b1;
      end
   endtask

   task automatic set_word(input int idx, input logic [WORD_W-1:0] w);
      req_data[idx*WORD_W +: WORD_W] = w;
   endtask

   // ---------------------------------------------------------------------------
   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++;
      if (req_ready !== '0) begin n_errors++; $display("FAIL reset_req_ready: got %b expected 0000", req_ready); end
      n_checks++;
      if (rsp_valid !== 1'b0) begin n_errors++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
      n_checks++;
      if (rsp_id !== 2'd0) begin n_errors++; $display("FAIL reset_rsp_id: got %0d expected 0", rsp_id); end
      n_checks++;
      if (rsp_count !== '0) begin n_errors++; $display("FAIL reset_rsp_count: got %0d expected 0", rsp_count); end
      n_checks++;
      if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      rst_n = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({busy, rsp_valid, busy_s, rsp_valid_s} !== 4'b0000) begin
         n_errors++; $display("FAIL idle_after_reset: got %b expected 0000", {busy, rsp_valid, busy_s, rsp_valid_s});
      end
   endtask

   // All requesters valid: grants 0,1,2,3,0 back to back, one per WORD_W+3.
   task automatic test_rotation();
      logic [WORD_W-1:0] words [NREQ];
      logic [NREQ-1:0]   gnt, exp_gnt;
      int                waited, lat, id;
      bit                ok;
      exp_t              e;
      words[0] = 16'hB0B0;
      words[1] = 16'hB6C0;
      words[2] = 16'h1234;
      words[3] = 16'hBBBB;
      pattern   = 4'b1011;
      rsp_ready = 1'b1;
      for (int i = 0; i < NREQ; i++) set_word(i, words[i]);
      req_valid = '1;
      for (int k = 0; k < 5; k++) begin
         id = k % NREQ;
         push_exp(id, ref_count(words[id], pattern));
         wait_grant(gnt, waited, ok);
         exp_gnt = '0;
         exp_gnt[id] = 1'b1;
         n_checks++;
         if (!ok || gnt !== exp_gnt) begin
            n_errors++; $display("FAIL rot_grant[%0d]: got %b expected %b", k, gnt, exp_gnt);
         end
         if (k > 0) begin
            n_checks++;
            if (waited !== 1) begin n_errors++; $display("FAIL rot_regrant_gap[%0d]: got %0d expected 1", k, waited); end
         end
         if (k == 4) begin
            @(negedge clk);
            req_valid = '0;
            wait_rsp(lat, ok);
            lat++;
         end else begin
            wait_rsp(lat, ok);
         end
         n_checks++;
         if (!ok || lat !== WORD_W + 2) begin
            n_errors++; $display("FAIL rot_latency[%0d]: got %0d expected %0d", k, lat, WORD_W + 2);
         end
         pop_exp(e);
         n_checks++;
         if (rsp_id !== e.id) begin n_errors++; $display("FAIL rot_id[%0d]: got %0d expected %0d", k, rsp_id, e.id); end
         n_checks++;
         if (rsp_count !== e.cnt) begin n_errors++; $display("FAIL rot_count[%0d]: got %0d expected %0d", k, rsp_count, e.cnt); end
      end
   endtask

   // Generic single-word run; the pattern input is disturbed during SHIFT.
   task automatic run_single(input string name, input int idx, input logic [WORD_W-1:0] w,
                             input logic [PAT_W-1:0] pat, input int exp_cnt);
      logic [NREQ-1:0] gnt, exp_gnt;
      int              waited, lat;
      bit              ok;
      exp_t            e;
      @(negedge clk);
      pattern = pat;
      set_word(idx, w);
      req_valid = '0;
      req_valid[idx] = 1'b1;
      push_exp(idx, exp_cnt);
      wait_grant(gnt, waited, ok);
      exp_gnt = '0;
      exp_gnt[idx] = 1'b1;
      n_checks++;
      if (!ok || gnt !== exp_gnt) begin n_errors++; $display("FAIL %s_grant: got %b expected %b", name, gnt, exp_gnt); end
      @(negedge clk);
      req_valid = '0;
      pattern   = ~pat;
      n_checks++;
      if (busy !== 1'b1) begin n_errors++; $display("FAIL %s_busy: got %b expected 1", name, busy); end
      // Counted from T+1, so the response is WORD_W+1 cycles away.
      wait_rsp(lat, ok);
      n_checks++;
      if (!ok || lat !== WORD_W + 1) begin n_errors++; $display("FAIL %s_latency: got %0d expected %0d", name, lat + 1, WORD_W + 2); end
      pop_exp(e);
      n_checks++;
      if (rsp_id !== e.id) begin n_errors++; $display("FAIL %s_id: got %0d expected %0d", name, rsp_id, e.id); end
      n_checks++;
      if (rsp_count !== e.cnt) begin n_errors++; $display("FAIL %s_count: got %0d expected %0d", name, rsp_count, e.cnt); end
   endtask

   task automatic test_patterns();
      run_single("b0b0", 0, 16'hB0B0, 4'b1011, 2);
`ifdef SEQ_DET_OVERLAP_EN
      run_single("overlap", 2, 16'hB6C0, 4'b1011, 3);
      run_single("zeros", 1, 16'h0000, 4'b0000, 13);
`else
      run_single("overlap", 2, 16'hB6C0, 4'b1011, 2);
      run_single("zeros", 1, 16'h0000, 4'b0000, 4);
`endif
   endtask

   // Response held for 10 cycles: fields stable, no grant; then prompt regrant.
   task automatic test_backpressure();
      logic [NREQ-1:0] gnt;
      int              waited, lat;
      bit              ok;
      exp_t            e;
      logic [12:0]     exp_vec;
      @(negedge clk);
      rsp_ready = 1'b0;
      pattern   = 4'b1011;
      set_word(3, 16'hBBBB);
      set_word(0, 16'hB0B0);
      req_valid = 4'b1000;
      push_exp(3, ref_count(16'hBBBB, 4'b1011));
      wait_grant(gnt, waited, ok);
      n_checks++;
      if (!ok || gnt !== 4'b1000) begin n_errors++; $display("FAIL bp_grant: got %b expected 1000", gnt); end
      @(negedge clk);
      req_valid = 4'b0001;
      wait_rsp(lat, ok);
      n_checks++;
      if (!ok || lat !== WORD_W + 1) begin n_errors++; $display("FAIL bp_latency: got %0d expected %0d", lat + 1, WORD_W + 2); end
      pop_exp(e);
      exp_vec = {1'b1, e.id, e.cnt, 4'b0000, 1'b1};
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         n_checks++;
         if ({rsp_valid, rsp_id, rsp_count, req_ready, busy} !== exp_vec) begin
            n_errors++;
            $display("FAIL bp_hold[%0d]: got %b expected %b", c,
                     {rsp_valid, rsp_id, rsp_count, req_ready, busy}, exp_vec);
         end
      end
      rsp_ready = 1'b1;
      push_exp(0, 2);
      @(negedge clk);
      #1;
      n_checks++;
      if ({rsp_valid, req_ready} !== 5'b0_0001) begin
         n_errors++; $display("FAIL bp_regrant: got %b expected 00001", {rsp_valid, req_ready});
      end
      @(negedge clk);
      req_valid = '0;
      wait_rsp(lat, ok);
      n_checks++;
      if (!ok || lat !== WORD_W + 1) begin n_errors++; $display("FAIL bp2_latency: got %0d expected %0d", lat + 1, WORD_W + 2); end
      pop_exp(e);
      n_checks++;
      if ({rsp_id, rsp_count} !== {e.id, e.cnt}) begin
         n_errors++; $display("FAIL bp2_rsp: got id %0d count %0d expected id %0d count %0d", rsp_id, rsp_count, e.id, e.cnt);
      end
   endtask

   // Reset in SHIFT cycle 5 aborts the word; rr pointer restarts at 0.
   task automatic test_reset_mid();
      logic [NREQ-1:0] gnt;
      int              waited, lat;
      bit              ok, seen;
      exp_t            e;
      @(negedge clk);
      pattern = 4'b1011;
      set_word(1, 16'hB0B0);
      req_valid = 4'b0010;
      wait_grant(gnt, waited, ok);
      n_checks++;
      if (!ok || gnt !== 4'b0010) begin n_errors++; $display("FAIL mid_grant: got %b expected 0010", gnt); end
      @(negedge clk);
      req_valid = '0;
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({busy, rsp_valid, req_ready, rsp_id, rsp_count} !== '0) begin
         n_errors++;
         $display("FAIL mid_reset_outputs: got %b expected all zero", {busy, rsp_valid, req_ready, rsp_id, rsp_count});
      end
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         if (rsp_valid) seen = 1'b1;
      end
      n_checks++;
      if (seen !== 1'b0) begin n_errors++; $display("FAIL mid_no_response: got %b expected 0", seen); end
      set_word(1, 16'hB0B0);
      set_word(3, 16'h1234);
      req_valid = 4'b1010;
      push_exp(1, 2);
      wait_grant(gnt, waited, ok);
      n_checks++;
      if (!ok || gnt !== 4'b0010) begin n_errors++; $display("FAIL mid_rr_restart: got %b expected 0010", gnt); end
      @(negedge clk);
      req_valid = '0;
      wait_rsp(lat, ok);
      n_checks++;
      if (!ok || lat !== WORD_W + 1) begin n_errors++; $display("FAIL mid_latency: got %0d expected %0d", lat + 1, WORD_W + 2); end
      pop_exp(e);
      n_checks++;
      if ({rsp_id, rsp_count} !== {e.id, e.cnt}) begin
         n_errors++; $display("FAIL mid_rsp: got id %0d count %0d expected id %0d count %0d", rsp_id, rsp_count, e.id, e.cnt);
      end
   endtask

   // Narrow counter on the second instance: 2-bit pattern 00 over a zero word
   // gives 8 (non-overlap) or 15 (overlap) hits, both clamp to 7.
   task automatic test_saturation();
      logic [15:0] w_tab [2];
      logic [1:0]  p_tab [2];
      int          c_tab [2];
      int          t;
      bit          ok;
      w_tab[0] = 16'h0000; p_tab[0] = 2'b00; c_tab[0] = 7;
      w_tab[1] = 16'h0003; p_tab[1] = 2'b11; c_tab[1] = 1;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         pattern_s = p_tab[k];
         req_data_s[k*16 +: 16] = w_tab[k];
         req_valid_s = '0;
         req_valid_s[k] = 1'b1;
         #1;
         n_checks++;
         if (req_ready_s[k] !== 1'b1) begin n_errors++; $display("FAIL sat_grant[%0d]: got %b", k, req_ready_s); end
         @(negedge clk);
         req_valid_s = '0;
         ok = 1'b0;
         t = 0;
         while (!ok && t < 100) begin
            @(negedge clk);
            t++;
            if (rsp_valid_s) ok = 1'b1;
         end
         n_checks++;
         if (!ok || rsp_count_s !== 3'(c_tab[k]) || rsp_id_s !== 1'(k)) begin
            n_errors++;
            $display("FAIL sat_rsp[%0d]: got valid %b id %0d count %0d expected id %0d count %0d",
                     k, ok, rsp_id_s, rsp_count_s, k, c_tab[k]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_rotation();
      test_patterns();
      test_backpressure();
      test_reset_mid();
      test_saturation();
      n_checks++;
      if (sb_q.size() !== 0) begin n_errors++; $display("FAIL scoreboard_leftover: got %0d expected 0", sb_q.size()); end
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
